// File: rtl/inst_fetch_ctrl_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : inst_fetch_ctrl_pkg
// Description : Shared types, encodings and constants for the instruction
//               fetch controller.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_fetch_ctrl_pkg;

    // Bus types shared by the PC stage, IF/ID and the instruction memory
    typedef logic [31:0] inst_addr_t;   // InstAddrBus
    typedef logic [31:0] inst_t;        // InstBus
    typedef logic [7:0]  fetch_timeout_t; // FetchTimeoutBus

    // Fetch FSM encodings
    typedef enum logic {
        FetchIdle = 1'b0,
        FetchWait = 1'b1
    } fetch_state_e;

    localparam inst_t NopInst    = 32'h0000_0000;
    localparam logic  RstEnable  = 1'b1;
    localparam logic  ChipEnable = 1'b1;
    localparam logic  BblEnable  = 1'b1;

    // Word-aligned fetch addresses have both low bits clear
    function automatic logic is_aligned(input inst_addr_t addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage : inst_fetch_ctrl_pkg
`default_nettype wire

// File: rtl/fetch_timeout_cnt.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : fetch_timeout_cnt
// Description : Saturating 8-bit wait counter; flags the last cycle a
//               memory acknowledge may still arrive.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_timeout_cnt
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam fetch_timeout_t LAST_CNT = fetch_timeout_t'(TIMEOUT - 1);

    fetch_timeout_t cnt_q;

    // Count wait cycles, restart on clear, hold at all-ones
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != 8'hFF)) begin
            cnt_q <= cnt_q + 8'd1;
        end
    end

    assign tc_o = (cnt_q == LAST_CNT);

endmodule : fetch_timeout_cnt
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : inst_fetch_ctrl
// Description : Instruction-fetch responder between the PC register and the
//               instruction memory, with a one-entry holding register that
//               answers repeated fetches of the same address immediately.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch_ctrl
    import inst_fetch_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    input  logic        flush_i,
    output logic [31:0] inst_o,
    output logic        inst_valid_o,
    output logic        stall_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);

    fetch_state_e state_q;
    logic         mem_req_q;
    inst_addr_t   mem_addr_q;
    inst_addr_t   held_pc_q;
    inst_t        held_inst_q;
    logic         held_valid_q;
    logic         drop_q;
    logic         err_q;

    logic w_hit;
    logic w_misalign;
    logic w_miss;
    logic w_tc;

    assign w_hit      = (ce_i == ChipEnable) && held_valid_q && (held_pc_q == pc_i);
    assign w_misalign = (ce_i == ChipEnable) && !w_hit && !is_aligned(pc_i);
    assign w_miss     = (ce_i == ChipEnable) && !w_hit &&  is_aligned(pc_i);

    // Counter is held at zero while idle, so it starts fresh on every request
    fetch_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q == FetchIdle),
        .en_i  (state_q == FetchWait),
        .tc_o  (w_tc)
    );

    // Instruction/stall response to the PC stage; hits answer in the same cycle
    always_comb begin
        inst_o       = NopInst;
        inst_valid_o = 1'b0;
        stall_o      = 1'b0;
        if (state_q == FetchWait) begin
            stall_o = BblEnable;
        end else if (ce_i == ChipEnable) begin
            if (w_hit) begin
                inst_o       = held_inst_q;
                inst_valid_o = 1'b1;
            end else begin
                // Misses and misaligned fetches both hold the PC for a cycle
                stall_o = BblEnable;
            end
        end
    end

    // Fetch FSM with registered memory interface, holding register and error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state_q      <= FetchIdle;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            held_pc_q    <= '0;
            held_inst_q  <= NopInst;
            held_valid_q <= 1'b0;
            drop_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                FetchIdle: begin
                    // A redirect invalidates the holding register and starts nothing
                    if (flush_i) begin
                        held_valid_q <= 1'b0;
                    end else if (w_misalign) begin
                        held_pc_q    <= pc_i;
                        held_inst_q  <= NopInst;
                        held_valid_q <= 1'b1;
                        err_q        <= 1'b1;
                    end else if (w_miss) begin
                        mem_addr_q <= pc_i;
                        mem_req_q  <= 1'b1;
                        drop_q     <= 1'b0;
                        state_q    <= FetchWait;
                    end
                end
                FetchWait: begin
                    // A flush in the completing cycle also discards the result
                    if (mem_ack_i) begin
                        held_inst_q  <= mem_rdata_i;
                        held_pc_q    <= mem_addr_q;
                        held_valid_q <= !(drop_q || flush_i);
                        mem_req_q    <= 1'b0;
                        drop_q       <= 1'b0;
                        state_q      <= FetchIdle;
                    end else if (w_tc) begin
                        held_inst_q  <= NopInst;
                        held_pc_q    <= mem_addr_q;
                        held_valid_q <= !(drop_q || flush_i);
                        mem_req_q    <= 1'b0;
                        drop_q       <= 1'b0;
                        err_q        <= 1'b1;
                        state_q      <= FetchIdle;
                    end else if (flush_i) begin
                        drop_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= FetchIdle;
                end
            endcase
        end
    end

    assign err_o      = err_q;
    assign mem_req_o  = mem_req_q;
    assign mem_addr_o = mem_addr_q;

endmodule : inst_fetch_ctrl
`default_nettype wire

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Instruction-fetch responder between the PC register and the instruction memory. It accepts the fetch address and chip-enable from the PC stage and runs a multi-cycle request/acknowledge transaction to the memory. It returns the instruction word to the IF/ID stage and drives the stall (`bbl`) back to the PC stage while a fetch is outstanding. A one-entry holding register returns repeated fetches of the same address with zero latency and no memory transaction.

## Interface
- `TIMEOUT`, default 64: cycles waited for `mem_ack_i` before abandoning a request; legal range 2..255.
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `pc_i` in 32: fetch address from the PC register.
- `ce_i` in 1: fetch enable from the PC register (`ChipEnable` = 1).
- `flush_i` in 1: branch taken this cycle; the in-flight fetch result must be discarded.
- `inst_o` out 32: instruction to IF/ID.
- `inst_valid_o` out 1: `inst_o` corresponds to the current `pc_i`.
- `stall_o` out 1: drives `bbl` of the PC register; 1 = hold PC.
- `err_o` out 1: one-cycle pulse on a misaligned fetch or a timeout.
- `mem_req_o` out 1: memory request.
- `mem_addr_o` out 32: memory word address.
- `mem_ack_i` in 1: memory acknowledge; `mem_rdata_i` is valid in the same cycle.
- `mem_rdata_i` in 32: memory read data.

## Operation
- Holding register: `held_pc` (32), `held_inst` (32), `held_valid` (1).
- hit = `ce_i` && `held_valid` && `held_pc == pc_i`.
- States: IDLE, WAIT.
- IDLE behaviour:
  - `ce_i` = 0: `inst_o` = 0, `inst_valid_o` = 0, `stall_o` = 0, no request.
  - hit: `inst_o` = `held_inst`, `inst_valid_o` = 1, `stall_o` = 0 (combinational).
  - `ce_i` && `pc_i[1:0]` != 0: no request. Load the holding register with `pc_i` and NOP (32'h0), set `held_valid`, pulse `err_o` next cycle.
  - Otherwise (aligned miss): `stall_o` = 1 combinationally. Register `mem_addr_o` <= `pc_i`, `mem_req_o` <= 1, clear timeout counter, go to WAIT.
- WAIT behaviour:
  - `stall_o` = 1 and `inst_valid_o` = 0 regardless of `ce_i`.
  - `mem_req_o` and `mem_addr_o` stay stable until ack or timeout.
- `mem_ack_i` in WAIT:
  - Capture `mem_rdata_i` into `held_inst` and `mem_addr_o` into `held_pc`.
  - Set `held_valid` unless the drop flag is set; if set, clear `held_valid`.
  - Deassert `mem_req_o`, clear the drop flag, go to IDLE.
- `flush_i` in WAIT: set the drop flag. The request is not withdrawn; memory must still ack.
- `flush_i` in IDLE: clear `held_valid`.
- `flush_i` and `mem_ack_i` in the same cycle: result is dropped.
- Timeout: counter reaches `TIMEOUT`-1 without ack:
  - Deassert `mem_req_o`; `held_inst` <= NOP, `held_pc` <= `mem_addr_o`.
  - `held_valid` <= !drop; pulse `err_o`; go to IDLE.
  - Counter saturates; width 8 bits.
- `ce_i` falling during WAIT has no effect on the transaction.
- Reset mid-transaction: FSM goes to IDLE immediately, `mem_req_o` drops asynchronously. A late `mem_ack_i` seen in IDLE is ignored.

## Timing
- Reset values: state IDLE, `mem_req_o` 0, `mem_addr_o` 0, `held_valid` 0, `held_pc` 0, `held_inst` 0, `err_o` 0. Combinational outputs: `inst_o` 0, `inst_valid_o` 0, `stall_o` 0 (with `ce_i` = 0).
- Hit latency: 0 cycles; `inst_o` is valid in the same cycle as `pc_i`.
- Miss:
  - `pc_i` first presented in cycle N with `stall_o` = 1.
  - `mem_req_o` is high from N+1.
  - Ack in cycle M ≥ N+1 gives `inst_valid_o` = 1, `stall_o` = 0 in cycle M+1.
  - Minimum miss latency is 2 cycles.
- `err_o` is high exactly one cycle, the cycle after the triggering event.
- A new request never issues in the same cycle as an ack; back-to-back misses are spaced ≥ 1 IDLE cycle.

## Structure
- Add to `defines.v`:
  - `FetchIdle`/`FetchWait` state encodings.
  - `NopInst` 32'h00000000.
  - `FetchTimeoutBus` [7:0].
  - Reuse `InstAddrBus`, `InstBus`, `RstEnable`, `ChipEnable`, `BblEnable`.
- One sub-module, `fetch_timeout_cnt`:
  - Clear/enable inputs and terminal-count output.
  - `TIMEOUT` parameter.
  - Same clock/reset.

## Test plan
- Reset, then `ce_i` = 1, `pc_i` = 0x0; memory acks 3 cycles after req with 0x3C010001 → `stall_o` high 4 cycles, then `inst_o` = 0x3C010001 and `inst_valid_o` = 1, `mem_addr_o` = 0x0.
- Same `pc_i` = 0x0 held 5 more cycles → no new `mem_req_o`, `inst_o` stable, `stall_o` = 0.
- `pc_i` = 0x4, `flush_i` pulsed in WAIT, ack data 0xDEADBEEF → `held_valid` = 0. Re-presenting 0x4 issues a fresh request.
- `pc_i` = 0x6 → no request, `inst_o` = 0 valid, `err_o` one-cycle pulse.
- `TIMEOUT` = 4, no ack → `mem_req_o` drops after 4 cycles, `err_o` pulses, `inst_o` = 0 valid for that pc.
- `rst` asserted mid-WAIT → `mem_req_o` = 0 immediately. An ack arriving after reset release is ignored, and the first fetch after release misses.
